contador_param_limites: RTL and testbench

- Parametrised successor of the 4-bit switch counter: an N-bit up/down counter with a run-time step size and programmable lower and upper limits.
- Three boundary modes: wrap, saturate, bounce (ping-pong with an internal direction FSM). Also provides load, freeze, a registered boundary-event pulse and a saturating event counter.
- Sits between the SWI decode logic and the LCD/LED display outputs of top.

---
 rtl/contador_param_limites.sv | 82 ++++++++
 tb/tb_contador_param_limites.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/contador_param_limites.sv
// contador_param_limites: N-bit up/down counter with run-time step, programmable limits and wrap/saturate/bounce modes
module contador_param_limites #(
  parameter int NBITS = 8,
  parameter int STEP_BITS = 4,
  parameter int EVT_BITS = 4,
  parameter logic [NBITS-1:0] RESET_VALUE = '0
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 congelamento,
  input  logic                 carregar,
  input  logic [NBITS-1:0]     valor_carga,
  input  logic                 decrescente,
  input  logic [STEP_BITS-1:0] passo,
  input  logic [1:0]           modo,
  input  logic [NBITS-1:0]     lim_inf,
  input  logic [NBITS-1:0]     lim_sup,
  output logic [NBITS-1:0]     counter,
  output logic                 dir_down,
  output logic                 tc,
  output logic [EVT_BITS-1:0]  n_eventos,
  output logic                 no_sup,
  output logic                 no_inf,
  output logic                 erro
);
  localparam int W = NBITS + STEP_BITS + 1;
  typedef enum logic {SOBE, DESCE} estado_t;
  estado_t estado, estado_nxt;
  logic [NBITS-1:0] counter_nxt, carga;
  logic [EVT_BITS-1:0] ev_nxt;
  logic signed [W-1:0] c_s, p_s, inf_s, sup_s, soma;
  logic dn, evento, fora, dir_nxt, tc_nxt;
  assign erro = lim_inf > lim_sup;
  assign no_sup = counter == lim_sup;
  assign no_inf = counter == lim_inf;
  assign dn = modo == 2'b10 ? estado == DESCE : decrescente;
  // widened signed arithmetic so a step past either limit never wraps internally
  assign c_s = signed'(W'(counter));
  assign p_s = signed'(W'(passo));
  assign inf_s = signed'(W'(lim_inf));
  assign sup_s = signed'(W'(lim_sup));
  assign soma = dn ? c_s - p_s : c_s + p_s;
  assign evento = dn ? soma < inf_s : soma > sup_s;
  assign fora = counter > lim_sup || counter < lim_inf;
  assign carga = erro ? valor_carga : valor_carga < lim_inf ? lim_inf : valor_carga > lim_sup ? lim_sup : valor_carga;
  always_comb begin
    counter_nxt = counter;
    estado_nxt = estado;
    dir_nxt = dir_down;
    tc_nxt = 1'b0;
    ev_nxt = n_eventos;
    if (carregar) counter_nxt = carga;
    else if (!(congelamento || erro)) begin
      dir_nxt = dn;
      if (fora) counter_nxt = counter > lim_sup ? lim_sup : lim_inf;
      else if (evento) begin
        tc_nxt = 1'b1;
        ev_nxt = &n_eventos ? n_eventos : n_eventos + EVT_BITS'(1);
        counter_nxt = modo == 2'b00 ? (dn ? lim_sup : lim_inf) : (dn ? lim_inf : lim_sup);
        if (modo == 2'b10) begin
          estado_nxt = estado == SOBE ? DESCE : SOBE;
          dir_nxt = !dn;
        end
      end else counter_nxt = soma[NBITS-1:0];
    end
  end
  always_ff @(posedge clk_2) begin
    if (reset) begin
      counter <= RESET_VALUE;
      estado <= SOBE;
      dir_down <= 1'b0;
      tc <= 1'b0;
      n_eventos <= '0;
    end else begin
      counter <= counter_nxt;
      estado <= estado_nxt;
      dir_down <= dir_nxt;
      tc <= tc_nxt;
      n_eventos <= ev_nxt;
    end
  end
endmodule

// File: tb/tb_contador_param_limites.sv
// tb_contador_param_limites: directed and randomized checks against a rule-level reference model
module tb_contador_param_limites;
  localparam int N = 8, S = 4, E = 4;
  logic clk_2 = 0, reset = 0, congelamento = 0, carregar = 0, decrescente = 0;
  logic [N-1:0] valor_carga = 0, lim_inf = 0, lim_sup = 0, counter;
  logic [S-1:0] passo = 0;
  logic [1:0] modo = 0;
  logic dir_down, tc, no_sup, no_inf, erro;
  logic [E-1:0] n_eventos;
  int checks = 0, errors = 0;
  int m_cnt = 0, m_ev = 0;
  bit m_fsm = 0, m_dir = 0, m_tc = 0;

  always #5 clk_2 = ~clk_2;

  contador_param_limites #(.NBITS(N), .STEP_BITS(S), .EVT_BITS(E), .RESET_VALUE('0)) dut (
    .clk_2(clk_2), .reset(reset), .congelamento(congelamento), .carregar(carregar),
    .valor_carga(valor_carga), .decrescente(decrescente), .passo(passo), .modo(modo),
    .lim_inf(lim_inf), .lim_sup(lim_sup), .counter(counter), .dir_down(dir_down),
    .tc(tc), .n_eventos(n_eventos), .no_sup(no_sup), .no_inf(no_inf), .erro(erro)
  );

  task automatic model();
    int li, ls, p, v, nxt;
    bit dn, ev;
    li = lim_inf; ls = lim_sup; p = passo; v = valor_carga;
    m_tc = 0;
    if (reset) begin
      m_cnt = 0; m_fsm = 0; m_dir = 0; m_ev = 0;
    end else if (carregar) begin
      m_cnt = (li > ls) ? v : (v < li) ? li : (v > ls) ? ls : v;
    end else if (!congelamento && li <= ls) begin
      dn = (modo == 2) ? m_fsm : decrescente;
      if (m_cnt > ls) m_cnt = ls;
      else if (m_cnt < li) m_cnt = li;
      else begin
        nxt = dn ? m_cnt - p : m_cnt + p;
        ev = dn ? (nxt < li) : (nxt > ls);
        if (!ev) m_cnt = nxt;
        else begin
          m_tc = 1;
          if (m_ev < 2**E - 1) m_ev++;
          if (modo == 0) m_cnt = dn ? ls : li;
          else m_cnt = dn ? li : ls;
          if (modo == 2) m_fsm = !m_fsm;
        end
      end
      m_dir = (modo == 2) ? m_fsm : decrescente;
    end
  endtask

  task automatic tick();
    model();
    @(posedge clk_2);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; tick(); reset = 0;
    checks++; if (counter !== 8'd0) begin errors++; $display("FAIL reset_counter got %0d want 0", counter); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %b want 0", tc); end
    checks++; if (n_eventos !== 4'd0) begin errors++; $display("FAIL reset_nev got %0d want 0", n_eventos); end
    checks++; if (dir_down !== 1'b0) begin errors++; $display("FAIL reset_dir got %b want 0", dir_down); end
  endtask

  task automatic test_wrap();
    modo = 0; lim_inf = 0; lim_sup = 15; passo = 1; decrescente = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++; if (counter !== 8'(i) || tc !== 1'b0) begin errors++; $display("FAIL wrap_step%0d got %0d/%b want %0d/0", i, counter, tc, i); end
    end
    checks++; if (no_sup !== 1'b1) begin errors++; $display("FAIL wrap_no_sup got %b want 1", no_sup); end
    tick();
    checks++; if (counter !== 8'd0 || tc !== 1'b1 || n_eventos !== 4'd1) begin errors++; $display("FAIL wrap_event got %0d/%b/%0d want 0/1/1", counter, tc, n_eventos); end
    tick();
    checks++; if (counter !== 8'd1 || tc !== 1'b0) begin errors++; $display("FAIL wrap_after got %0d/%b want 1/0", counter, tc); end
  endtask

  task automatic test_saturate();
    reset = 1; tick(); reset = 0;
    modo = 1; lim_inf = 0; lim_sup = 15; passo = 3; decrescente = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (counter !== 8'(3 * i) || tc !== 1'b0) begin errors++; $display("FAIL sat_step%0d got %0d/%b want %0d/0", i, counter, tc, 3 * i); end
    end
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++; if (counter !== 8'd15 || tc !== 1'b1 || n_eventos !== 4'(k > 15 ? 15 : k)) begin
        errors++; $display("FAIL sat_hold%0d got %0d/%b/%0d want 15/1/%0d", k, counter, tc, n_eventos, k > 15 ? 15 : k);
      end
    end
  endtask

  task automatic test_bounce();
    int ec[7] = '{14, 18, 20, 16, 12, 10, 14};
    bit et[7] = '{0, 0, 1, 0, 0, 1, 0};
    bit ed[7] = '{0, 0, 1, 1, 1, 0, 0};
    reset = 1; tick(); reset = 0;
    modo = 2; lim_inf = 10; lim_sup = 20; passo = 4; decrescente = 1;
    carregar = 1; valor_carga = 10; tick(); carregar = 0;
    checks++; if (counter !== 8'd10 || no_inf !== 1'b1) begin errors++; $display("FAIL bounce_load got %0d/%b want 10/1", counter, no_inf); end
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (counter !== 8'(ec[i]) || tc !== et[i] || dir_down !== ed[i]) begin
        errors++; $display("FAIL bounce_step%0d got %0d/%b/%b want %0d/%b/%b", i, counter, tc, dir_down, ec[i], et[i], ed[i]);
      end
    end
  endtask

  task automatic test_priority();
    modo = 0; lim_inf = 0; lim_sup = 255; passo = 5; decrescente = 0;
    carregar = 1; valor_carga = 37; tick(); carregar = 0;
    congelamento = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (counter !== 8'd37 || tc !== 1'b0) begin errors++; $display("FAIL freeze%0d got %0d/%b want 37/0", i, counter, tc); end
    end
    carregar = 1; valor_carga = 200; tick();
    checks++; if (counter !== 8'd200) begin errors++; $display("FAIL load_over_freeze got %0d want 200", counter); end
    reset = 1; tick(); reset = 0; carregar = 0; congelamento = 0;
    checks++; if (counter !== 8'd0) begin errors++; $display("FAIL reset_over_load got %0d want 0", counter); end
  endtask

  task automatic test_limits();
    lim_inf = 8; lim_sup = 12; passo = 3; modo = 1;
    carregar = 1; valor_carga = 5; tick();
    checks++; if (counter !== 8'd8 || no_inf !== 1'b1) begin errors++; $display("FAIL clamp_low got %0d/%b want 8/1", counter, no_inf); end
    valor_carga = 250; tick(); carregar = 0;
    checks++; if (counter !== 8'd12 || no_sup !== 1'b1) begin errors++; $display("FAIL clamp_high got %0d/%b want 12/1", counter, no_sup); end
    lim_inf = 30; lim_sup = 10; #1;
    checks++; if (erro !== 1'b1) begin errors++; $display("FAIL erro_flag got %b want 1", erro); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (counter !== 8'd12 || tc !== 1'b0) begin errors++; $display("FAIL erro_hold%0d got %0d/%b want 12/0", i, counter, tc); end
    end
    lim_inf = 20; lim_sup = 40; tick();
    checks++; if (counter !== 8'd20 || tc !== 1'b0) begin errors++; $display("FAIL out_of_range got %0d/%b want 20/0", counter, tc); end
  endtask

  task automatic test_reset_mid();
    reset = 1; tick(); reset = 0;
    modo = 2; lim_inf = 0; lim_sup = 20; passo = 4;
    carregar = 1; valor_carga = 16; tick(); carregar = 0;
    tick(); tick(); tick();
    checks++; if (counter !== 8'd16 || dir_down !== 1'b1) begin errors++; $display("FAIL mid_setup got %0d/%b want 16/1", counter, dir_down); end
    reset = 1; tick(); reset = 0;
    checks++; if (counter !== 8'd0 || tc !== 1'b0 || n_eventos !== 4'd0 || dir_down !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %0d/%b/%0d/%b want 0/0/0/0", counter, tc, n_eventos, dir_down);
    end
    passo = 2; tick();
    checks++; if (counter !== 8'd2 || dir_down !== 1'b0) begin errors++; $display("FAIL mid_after got %0d/%b want 2/0", counter, dir_down); end
  endtask

  task automatic test_random();
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(63) == 0);
      carregar = ($urandom_range(15) == 0);
      congelamento = ($urandom_range(15) == 0);
      valor_carga = 8'($urandom);
      decrescente = 1'($urandom);
      passo = 4'($urandom);
      if ($urandom_range(7) == 0) modo = 2'($urandom);
      if ($urandom_range(31) == 0) begin
        lim_inf = 8'($urandom_range(60));
        lim_sup = ($urandom_range(9) == 0) ? lim_inf : 8'($urandom_range(255, 30));
      end
      tick();
      checks++;
      if (counter !== 8'(m_cnt) || dir_down !== m_dir || tc !== m_tc || n_eventos !== 4'(m_ev) ||
          no_sup !== (8'(m_cnt) == lim_sup) || no_inf !== (8'(m_cnt) == lim_inf) || erro !== (lim_inf > lim_sup)) begin
        errors++;
        $display("FAIL rand%0d got cnt=%0d dir=%b tc=%b nev=%0d sup=%b inf=%b erro=%b want cnt=%0d dir=%b tc=%b nev=%0d",
                 i, counter, dir_down, tc, n_eventos, no_sup, no_inf, erro, m_cnt, m_dir, m_tc, m_ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_bounce();
    test_priority();
    test_limits();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
